// File: rtl/game_round_pkg.sv
// Shared state encoding and default game constants for the round scheduler.
package game_round_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_START_GAME  = 3'd1,
    ST_GAP         = 3'd2,
    ST_START_ROUND = 3'd3,
    ST_PLAY        = 3'd4,
    ST_END_ROUND   = 3'd5,
    ST_GAME_OVER   = 3'd6
  } round_state_t;

  localparam int WIN_SCORE   = 3;
  localparam int START_LIVES = 3;
  localparam int GAP_CYCLES  = 16;

endpackage

// File: rtl/round_gap_timer.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module round_gap_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/game_round_scheduler.sv
// Round/score sequencer: owns score, lives and the game timer handshake and
// issues registered one-cycle strobes to the sprite datapath.
module game_round_scheduler #(
  parameter int WIN_SCORE   = game_round_pkg::WIN_SCORE,
  parameter int START_LIVES = game_round_pkg::START_LIVES,
  parameter int GAP_CYCLES  = game_round_pkg::GAP_CYCLES,
  parameter int GAP_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       launch_key,
  input  logic       hit,
  input  logic       crash,
  input  logic       miss,
  input  logic       timer_running,
  output logic       timer_start,
  output logic       round_start,
  output logic       play_enable,
  output logic [2:0] heart_clear,
  output logic       heart_init,
  output logic [2:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       game_won,
  output logic [2:0] state_dbg
);

  import game_round_pkg::*;

  localparam logic [2:0]       WIN_VAL   = 3'(WIN_SCORE);
  localparam logic [1:0]       LIVES_VAL = 2'(START_LIVES);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

  round_state_t state, next_state;

  logic       launch_prev;
  logic       launch_rise;
  logic       gap_load, gap_dec, gap_done;
  logic       timer_start_n, round_start_n, heart_init_n;
  logic [2:0] heart_clear_n, score_n;
  logic [1:0] lives_n;
  logic       game_won_n;

  // Edge detector flop resets high so a key held through reset is not a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      launch_prev <= 1'b1;
    end else begin
      launch_prev <= launch_key;
    end
  end

  assign launch_rise = launch_key & ~launch_prev;

  round_gap_timer #(
    .WIDTH(GAP_W)
  ) u_gap_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (gap_load),
    .load_value(GAP_LOAD),
    .dec       (gap_dec),
    .done      (gap_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:        if (launch_rise) next_state = ST_START_GAME;
      ST_START_GAME:  next_state = ST_GAP;
      ST_GAP:         if (gap_done) next_state = ST_START_ROUND;
      ST_START_ROUND: next_state = ST_PLAY;
      ST_PLAY: begin
        if (crash || hit || miss) next_state = ST_END_ROUND;
        else if (!timer_running)  next_state = ST_GAME_OVER;
      end
      ST_END_ROUND: begin
        if (score == WIN_VAL)                        next_state = ST_GAME_OVER;
        else if ((lives == 2'd0) || !timer_running)  next_state = ST_GAME_OVER;
        else                                         next_state = ST_GAP;
      end
      ST_GAME_OVER:   if (launch_rise) next_state = ST_START_GAME;
      default:        next_state = ST_IDLE;
    endcase
  end

  // Next values of every registered output; crash outranks hit outranks miss.
  always_comb begin
    timer_start_n = 1'b0;
    round_start_n = 1'b0;
    heart_init_n  = 1'b0;
    heart_clear_n = 3'b000;
    score_n       = score;
    lives_n       = lives;
    game_won_n    = game_won;
    gap_load      = 1'b0;
    gap_dec       = 1'b0;
    unique case (state)
      ST_START_GAME: begin
        score_n       = 3'd0;
        lives_n       = LIVES_VAL;
        timer_start_n = 1'b1;
        heart_init_n  = 1'b1;
        game_won_n    = 1'b0;
        gap_load      = 1'b1;
      end
      ST_GAP:         gap_dec = 1'b1;
      ST_START_ROUND: round_start_n = 1'b1;
      ST_PLAY: begin
        if (crash) begin
          lives_n = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
          unique case (lives)
            2'd3:    heart_clear_n = 3'b100;
            2'd2:    heart_clear_n = 3'b010;
            2'd1:    heart_clear_n = 3'b001;
            default: heart_clear_n = 3'b000;
          endcase
        end else if (hit) begin
          score_n = (score >= WIN_VAL) ? WIN_VAL : score + 3'd1;
        end else if (!miss && !timer_running) begin
          game_won_n = 1'b0;
        end
      end
      ST_END_ROUND: begin
        if (score == WIN_VAL)                        game_won_n = 1'b1;
        else if ((lives == 2'd0) || !timer_running)  game_won_n = 1'b0;
        else                                         gap_load   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_start <= 1'b0;
      round_start <= 1'b0;
      heart_init  <= 1'b0;
      heart_clear <= 3'b000;
      score       <= 3'd0;
      lives       <= LIVES_VAL;
      game_won    <= 1'b0;
      play_enable <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      timer_start <= timer_start_n;
      round_start <= round_start_n;
      heart_init  <= heart_init_n;
      heart_clear <= heart_clear_n;
      score       <= score_n;
      lives       <= lives_n;
      game_won    <= game_won_n;
      play_enable <= (next_state == ST_PLAY);
      game_over   <= (next_state == ST_GAME_OVER);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_game_round_scheduler.sv
// Directed bench for game_round_scheduler with hand-computed expectations.
module tb_game_round_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       launch_key, hit, crash, miss, timer_running;
  logic       timer_start, round_start, play_enable, heart_init;
  logic       game_over, game_won;
  logic [2:0] heart_clear, score, state_dbg;
  logic [1:0] lives;

  int checks = 0;
  int errors = 0;
  int roundStarts = 0;
  int base;
  int n;

  game_round_scheduler #(
    .WIN_SCORE(3), .START_LIVES(3), .GAP_CYCLES(16), .GAP_W(8)
  ) dut (
    .clk(clk), .rst(rst), .launch_key(launch_key), .hit(hit), .crash(crash),
    .miss(miss), .timer_running(timer_running), .timer_start(timer_start),
    .round_start(round_start), .play_enable(play_enable), .heart_clear(heart_clear),
    .heart_init(heart_init), .score(score), .lives(lives), .game_over(game_over),
    .game_won(game_won), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (round_start === 1'b1) roundStarts++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic h, input logic c,
                               input logic m, input logic t);
    launch_key    = l;
    hit           = h;
    crash         = c;
    miss          = m;
    timer_running = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitRoundStart(output int cycles);
    cycles = 0;
    while (round_start !== 1'b1 && cycles < 60) begin
      tick();
      cycles++;
    end
    checkOutput("round_start_seen", 32'(round_start), 32'd1);
  endtask

  // Launch edge, then verify the START_GAME strobes land in the first GAP cycle.
  task automatic startGame();
    applyStimulus(1, 0, 0, 0, 1);
    tick();
    checkOutput("start_state", 32'(state_dbg), 32'd1);
    checkOutput("start_no_init_yet", 32'(heart_init), 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    tick();
    checkOutput("gap_state", 32'(state_dbg), 32'd2);
    checkOutput("heart_init", 32'(heart_init), 32'd1);
    checkOutput("timer_start", 32'(timer_start), 32'd1);
    checkOutput("start_score", 32'(score), 32'd0);
    checkOutput("start_lives", 32'(lives), 32'd3);
    checkOutput("start_won", 32'(game_won), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 1);
    #12;
    checkOutput("rst_state", 32'(state_dbg), 32'd0);
    checkOutput("rst_score", 32'(score), 32'd0);
    checkOutput("rst_lives", 32'(lives), 32'd3);
    checkOutput("rst_strobes", 32'({timer_start, round_start, heart_init, heart_clear}), 32'd0);
    checkOutput("rst_levels", 32'({play_enable, game_over, game_won}), 32'd0);
    rst = 1'b1;
    tick();

    // Level inputs in IDLE must be ignored.
    applyStimulus(0, 1, 1, 1, 0);
    tick();
    checkOutput("idle_ignore_state", 32'(state_dbg), 32'd0);
    checkOutput("idle_ignore_lives", 32'(lives), 32'd3);
    applyStimulus(0, 0, 0, 0, 1);
    tick();

    // First game: gap timing, then three hits to a win.
    base = roundStarts;
    startGame();
    waitRoundStart(n);
    checkOutput("gap_latency", 32'(n), 32'd17);
    checkOutput("play_state", 32'(state_dbg), 32'd4);
    checkOutput("play_enable", 32'(play_enable), 32'd1);
    for (int r = 1; r <= 3; r++) begin
      if (r > 1) waitRoundStart(n);
      applyStimulus(0, 1, 0, 0, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput($sformatf("hit_score_%0d", r), 32'(score), 32'(r));
      checkOutput($sformatf("hit_end_round_%0d", r), 32'(state_dbg), 32'd5);
    end
    tick();
    checkOutput("win_over", 32'(game_over), 32'd1);
    checkOutput("win_won", 32'(game_won), 32'd1);
    checkOutput("win_state", 32'(state_dbg), 32'd6);
    repeat (20) tick();
    checkOutput("win_round_count", 32'(roundStarts - base), 32'd3);
    checkOutput("win_score_hold", 32'(score), 32'd3);

    // Second game: three crashes to a loss.
    startGame();
    waitRoundStart(n);
    for (int r = 0; r < 3; r++) begin
      logic [2:0] expHeart [3] = '{3'b100, 3'b010, 3'b001};
      applyStimulus(0, 0, 1, 0, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput($sformatf("crash_heart_%0d", r), 32'(heart_clear), 32'(expHeart[r]));
      checkOutput($sformatf("crash_lives_%0d", r), 32'(lives), 32'(2 - r));
      if (r < 2) begin
        tick();
        checkOutput($sformatf("crash_heart_clr_%0d", r), 32'(heart_clear), 32'd0);
        waitRoundStart(n);
      end
    end
    tick();
    checkOutput("loss_over", 32'(game_over), 32'd1);
    checkOutput("loss_won", 32'(game_won), 32'd0);
    checkOutput("loss_heart_clr", 32'(heart_clear), 32'd0);

    // Third game: simultaneous events, a miss, then timer expiry.
    startGame();
    waitRoundStart(n);
    applyStimulus(0, 1, 1, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("multi_lives", 32'(lives), 32'd2);
    checkOutput("multi_score", 32'(score), 32'd0);
    checkOutput("multi_heart", 32'(heart_clear), 32'd4);
    tick();
    checkOutput("multi_heart_clr", 32'(heart_clear), 32'd0);
    checkOutput("multi_gap", 32'(state_dbg), 32'd2);
    waitRoundStart(n);
    applyStimulus(0, 0, 0, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("miss_state", 32'(state_dbg), 32'd5);
    checkOutput("miss_score_lives", 32'({score, lives}), 32'({3'd0, 2'd2}));
    waitRoundStart(n);
    applyStimulus(0, 0, 0, 0, 0);
    tick();
    checkOutput("timeout_state", 32'(state_dbg), 32'd6);
    checkOutput("timeout_over", 32'(game_over), 32'd1);
    checkOutput("timeout_won", 32'(game_won), 32'd0);
    checkOutput("timeout_play_off", 32'(play_enable), 32'd0);
    startGame();

    // Reset in mid-GAP with the key held through release.
    repeat (3) tick();
    applyStimulus(1, 0, 0, 0, 1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_state", 32'(state_dbg), 32'd0);
    checkOutput("mid_rst_lives", 32'(lives), 32'd3);
    checkOutput("mid_rst_strobes", 32'({timer_start, round_start, heart_init, heart_clear}), 32'd0);
    tick();
    rst = 1'b1;
    base = roundStarts;
    repeat (5) tick();
    checkOutput("held_key_idle", 32'(state_dbg), 32'd0);
    checkOutput("held_key_no_init", 32'(heart_init), 32'd0);
    checkOutput("held_key_no_round", 32'(roundStarts - base), 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    tick();
    startGame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
